// File: rtl/pr_elastic_stage_pkg.sv
// Shared pipeline definitions: stage state encoding, RV32 NOP and the IF/ID bubble payload.
// Imported by every elastic pipeline register and by its bench.
package pr_elastic_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_t;

   localparam logic [31:0] RV32_NOP    = 32'h0000_0013;
   localparam logic [63:0] IFID_BUBBLE = {32'd0, RV32_NOP};

   // Number of payloads held in a given state, as reported on OCCUPANCY.
   function automatic logic [1:0] state_occupancy(input stage_state_t s);
      case (s)
         ST_ONE:  return 2'd1;
         ST_FULL: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used to count back-pressure cycles of an elastic stage.
module pr_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pr_elastic_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer, flush-to-bubble
// and a saturating back-pressure counter.
module pr_elastic_stage
   import pr_elastic_stage_pkg::*;
#(
   parameter int                DATA_W = 64,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter int                CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATA_W-1:0] OUT_DATA,
   input  logic              FLUSH,
   output logic [1:0]        OCCUPANCY,
   output logic [CNT_W-1:0]  STALL_CNT,
   input  logic              CNT_CLR
);

   stage_state_t      state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              ready_q, ready_d;
   logic              accept;
   logic              emit;

   assign accept    = IN_VALID & ready_q;
   assign emit      = OUT_VALID & OUT_READY;
   assign IN_READY  = ready_q;
   assign OUT_VALID = (state_q != ST_EMPTY);
   assign OUT_DATA  = main_q;
   assign OCCUPANCY = state_occupancy(state_q);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_EMPTY;
         main_q  <= BUBBLE;
         skid_q  <= BUBBLE;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

   // Ready is computed from the next state so it can be registered without
   // any combinational path from OUT_READY to IN_READY.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (FLUSH) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
                  main_d  = IN_DATA;
               end
            end
            ST_ONE: begin
               if (accept && emit) begin
                  main_d = IN_DATA;
               end else if (accept) begin
                  state_d = ST_FULL;
                  skid_d  = IN_DATA;
               end else if (emit) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (emit) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      ready_d = (state_d != ST_FULL);
   end

   pr_sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .inc     (OUT_VALID & ~OUT_READY),
      .clr     (CNT_CLR),
      .count   (STALL_CNT)
   );

endmodule

// File: tb/tb_pr_elastic_stage.sv
// Bench for pr_elastic_stage: directed scenarios plus randomized traffic checked
// against a queue-based model of the stage.
module tb_pr_elastic_stage;
   import pr_elastic_stage_pkg::*;

   localparam int unsigned STALL_MAX = 65535;

   logic        CLK;
   logic        RESET_N;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        flush;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;
   logic        cnt_clr;

   logic        c_in_valid;
   logic        c_in_ready;
   logic [7:0]  c_in_data;
   logic        c_out_valid;
   logic        c_out_ready;
   logic [7:0]  c_out_data;
   logic        c_flush;
   logic [1:0]  c_occupancy;
   logic [2:0]  c_stall_cnt;
   logic        c_cnt_clr;

   int compared;
   int mismatched;

   logic [63:0] mq[$];
   logic [63:0] mLast;
   int unsigned mStall;
   int unsigned mEmits;
   int unsigned dutEmits;
   bit          lastStuck;

   pr_elastic_stage #(
      .DATA_W(64),
      .BUBBLE(IFID_BUBBLE),
      .CNT_W (16)
   ) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .IN_DATA   (in_data),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .OUT_DATA  (out_data),
      .FLUSH     (flush),
      .OCCUPANCY (occupancy),
      .STALL_CNT (stall_cnt),
      .CNT_CLR   (cnt_clr)
   );

   pr_elastic_stage #(
      .DATA_W(8),
      .BUBBLE(8'h5A),
      .CNT_W (3)
   ) dut_cnt (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .IN_VALID  (c_in_valid),
      .IN_READY  (c_in_ready),
      .IN_DATA   (c_in_data),
      .OUT_VALID (c_out_valid),
      .OUT_READY (c_out_ready),
      .OUT_DATA  (c_out_data),
      .FLUSH     (c_flush),
      .OCCUPANCY (c_occupancy),
      .STALL_CNT (c_stall_cnt),
      .CNT_CLR   (c_cnt_clr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      mLast     = IFID_BUBBLE;
      mStall    = 0;
      lastStuck = 1'b0;
   endtask

   // Reference behaviour: a FIFO of at most two payloads.
   task automatic modelUpdate();
      bit acc;
      bit emi;
      acc = in_valid && (mq.size() < 2);
      emi = (mq.size() > 0) && out_ready;
      if (cnt_clr) mStall = 0;
      else if ((mq.size() > 0) && !out_ready && (mStall < STALL_MAX)) mStall++;
      if (emi) mEmits++;
      lastStuck = in_valid && !acc;
      if (flush) begin
         mq.delete();
         mLast = IFID_BUBBLE;
      end else begin
         if (emi) mLast = mq.pop_front();
         if (acc) mq.push_back(in_data);
      end
   endtask

   task automatic checkModel();
      logic [63:0] expData;
      if (mq.size() > 0) expData = mq[0];
      else expData = mLast;
      checkOutput("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      checkOutput("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      checkOutput("out_data", out_data, expData);
      checkOutput("occupancy", 64'(occupancy), 64'(mq.size()));
      checkOutput("stall_cnt", 64'(stall_cnt), 64'(mStall));
   endtask

   // Drive at the falling edge, advance one rising edge, check at the next falling edge.
   task automatic applyStimulus(input logic iv, input logic [63:0] id, input logic ordy,
                                input logic fl, input logic clr);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      cnt_clr   = clr;
      if (out_valid && ordy) dutEmits++;
      @(posedge CLK);
      modelUpdate();
      @(negedge CLK);
      checkModel();
   endtask

   initial begin
      int unsigned expC;
      logic        iv;
      logic [63:0] id;
      compared   = 0;
      mismatched = 0;
      mEmits     = 0;
      dutEmits   = 0;
      RESET_N    = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      flush      = 1'b0;
      cnt_clr    = 1'b0;
      c_in_valid = 1'b0;
      c_in_data  = '0;
      c_out_ready = 1'b0;
      c_flush    = 1'b0;
      c_cnt_clr  = 1'b0;
      modelReset();
      repeat (2) @(negedge CLK);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_data", out_data, 64'h0000_0000_0000_0013);
      checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
      checkOutput("rst_cnt_bubble", 64'(c_out_data), 64'h5A);
      RESET_N = 1'b1;
      @(negedge CLK);

      $display("[TB] streaming");
      for (int k = 1; k <= 100; k++) begin
         applyStimulus(1'b1, 64'(k), 1'b1, 1'b0, 1'b0);
         checkOutput("stream_data", out_data, 64'(k));
         checkOutput("stream_ready", 64'(in_ready), 64'd1);
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("[TB] back-pressure");
      applyStimulus(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_occ_full", 64'(occupancy), 64'd2);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_head", out_data, 64'hA);
      applyStimulus(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_hold_head", out_data, 64'hA);
      applyStimulus(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_second", out_data, 64'hB);
      applyStimulus(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_third", out_data, 64'hC);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_drained", 64'(occupancy), 64'd0);

      $display("[TB] reset while full");
      applyStimulus(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 RESET_N = 1'b0;
      #1;
      checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("arst_out_data", out_data, IFID_BUBBLE);
      checkOutput("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      modelReset();

      $display("[TB] flush");
      applyStimulus(1'b1, 64'hA0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hB0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hD0, 1'b0, 1'b1, 1'b0);
      checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
      checkOutput("fl_out_data", out_data, IFID_BUBBLE);
      checkOutput("fl_occupancy", 64'(occupancy), 64'd0);
      applyStimulus(1'b1, 64'hE0, 1'b0, 1'b0, 1'b0);
      checkOutput("fl_first_after", out_data, 64'hE0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("[TB] stall counter saturation");
      c_in_valid  = 1'b1;
      c_in_data   = 8'h3C;
      c_out_ready = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      c_in_valid = 1'b0;
      checkOutput("cnt_valid", 64'(c_out_valid), 64'd1);
      checkOutput("cnt_data", 64'(c_out_data), 64'h3C);
      expC = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         expC = (expC < 7) ? expC + 1 : 7;
         checkOutput("cnt_sat", 64'(c_stall_cnt), 64'(expC));
      end
      c_cnt_clr = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      c_cnt_clr = 1'b0;
      checkOutput("cnt_clear", 64'(c_stall_cnt), 64'd0);
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("cnt_resume", 64'(c_stall_cnt), 64'd1);
      c_out_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("cnt_drained", 64'(c_out_valid), 64'd0);

      $display("[TB] random traffic");
      iv = 1'b0;
      id = '0;
      for (int n = 0; n < 10000; n++) begin
         if (!lastStuck) begin
            iv = ($urandom_range(99) < 70);
            id = {$urandom, $urandom};
         end
         applyStimulus(iv, id, ($urandom_range(99) < 60), ($urandom_range(99) < 3),
                       ($urandom_range(99) < 2));
      end
      checkOutput("emit_count", 64'(dutEmits), 64'(mEmits));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
